// File: rtl/rv_lsu_if.sv
// Core-to-LSU request/response channel plus LSU-to-RAM port A signals.
// master = core and RAM side, slave = the load/store unit.
interface rv_lsu_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/rv_lsu.sv
// Single-outstanding load/store unit with read-modify-write for sub-word stores.
// Optional event counters are built when RV_LSU_PERF_EN is defined.
module rv_lsu #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  rv_lsu_if.slave     bus,
  output logic [31:0] cnt_load,
  output logic [31:0] cnt_store,
  output logic [31:0] cnt_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_RSP, S_ERR_RSP
  } state_t;

  state_t           state_q, state_d;
  logic             we_q, uns_q;
  logic [1:0]       size_q;
  logic [AW+1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q, rdata_q;
  logic [WIDTH-1:0] load_ext, merged;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             err_acc, accept;

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign err_acc = (bus.req_size == 2'd3)
                || (bus.req_size == 2'd1 && bus.req_addr[0])
                || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00)
                || ((bus.req_addr >> (AW + 2)) != 32'd0);

  always_comb begin
    state_d  = state_q;
    byte_sel = bus.ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = bus.ram_rdata[{addr_q[1], 4'b0000} +: 16];
    merged   = bus.ram_rdata;
    load_ext = bus.ram_rdata;
    case (size_q)
      2'd0: begin
        load_ext = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'd1: begin
        load_ext = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        if (err_acc)                                state_d = S_ERR_RSP;
        else if (bus.req_we && bus.req_size == 2'd2) state_d = S_WRITE;
        else                                        state_d = S_READ;
      end
      S_READ:    state_d = S_WAIT;
      S_WAIT:    state_d = we_q ? S_WRITE : S_RSP;
      S_WRITE:   state_d = S_RSP;
      S_RSP:     state_d = S_IDLE;
      S_ERR_RSP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr[AW+1:0];
        wdata_q <= bus.req_wdata;
      end
      // Sub-word stores reuse the store-data register for the merged word.
      if (state_q == S_WAIT && we_q)
        wdata_q <= merged;
      if (state_q == S_WAIT && !we_q)
        rdata_q <= load_ext;
      else if (state_q == S_WRITE || (accept && err_acc))
        rdata_q <= '0;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RSP) || (state_q == S_ERR_RSP);
  assign bus.rsp_err   = (state_q == S_ERR_RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.ram_en    = (state_q == S_READ) || (state_q == S_WRITE);
  assign bus.ram_we    = (state_q == S_WRITE);
  assign bus.ram_addr  = addr_q[AW+1:2];
  assign bus.ram_wdata = (state_q == S_WRITE) ? wdata_q : '0;

`ifdef RV_LSU_PERF_EN
  logic [31:0] cnt_load_q, cnt_store_q, cnt_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_err_q   <= '0;
    end else begin
      if (state_q == S_RSP && !we_q) cnt_load_q  <= cnt_load_q + 32'd1;
      if (state_q == S_RSP && we_q)  cnt_store_q <= cnt_store_q + 32'd1;
      if (state_q == S_ERR_RSP)      cnt_err_q   <= cnt_err_q + 32'd1;
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_err   = cnt_err_q;
`else
  assign cnt_load  = 32'd0;
  assign cnt_store = 32'd0;
  assign cnt_err   = 32'd0;
`endif
endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu with a behavioural RAM on port A.
module tb_rv_lsu;
  logic        clk;
  logic        rst;
  logic [31:0] cnt_load, cnt_store, cnt_err;
  logic [31:0] mem [0:1023];
  int          total;
  int          bad;

  rv_lsu_if #(.WIDTH(32), .DEPTH(1024)) bus ();

  rv_lsu #(.WIDTH(32), .DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cnt_load  (cnt_load),
    .cnt_store (cnt_store),
    .cnt_err   (cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request and watch 8 cycles after the accept edge.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_en);
    int          lat;
    int          en_cnt;
    logic [31:0] rd;
    logic        er;
    logic        stray;
    logic        rdy1;
    lat = 0; en_cnt = 0; rd = '0; er = 1'b0; stray = 1'b0; rdy1 = 1'b1;
    @(negedge clk);
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    chk({tag, ":ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) rdy1 = bus.req_ready;
      if (bus.ram_en) en_cnt++;
      if (bus.rsp_valid && lat == 0) begin
        lat = c;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
      end else if (!bus.rsp_valid && bus.rsp_err) begin
        stray = 1'b1;
      end
    end
    chk({tag, ":lat"},    lat, exp_lat);
    chk({tag, ":rdata"},  rd, exp_rd);
    chk({tag, ":err"},    {31'd0, er}, {31'd0, exp_err});
    chk({tag, ":ram_en"}, en_cnt, exp_en);
    chk({tag, ":busy"},   {31'd0, rdy1}, 32'd0);
    chk({tag, ":stray"},  {31'd0, stray}, 32'd0);
  endtask

  initial begin
    int   seen_en;
    int   seen_rsp;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.ram_rdata    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:ready",     {31'd0, bus.req_ready}, 32'd1);
    chk("rst:rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst:rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst:rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst:ram_en",    {31'd0, bus.ram_en}, 32'd0);
    chk("rst:ram_we",    {31'd0, bus.ram_we}, 32'd0);
    chk("rst:ram_addr",  {22'd0, bus.ram_addr}, 32'd0);
    chk("rst:ram_wdata", bus.ram_wdata, 32'd0);
    chk("rst:cnt_load",  cnt_load, 32'd0);
    chk("rst:cnt_store", cnt_store, 32'd0);
    chk("rst:cnt_err",   cnt_err, 32'd0);
    rst = 1'b0;

    //      tag      we    sz    uns   addr          wdata          lat rdata          err   en
    do_req("sw10",  1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 2, 32'h0,        1'b0, 1);
    chk("mem4_sw", mem[4], 32'hDEADBEEF);
    do_req("lw10",  1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 1'b0, 1);
    do_req("sb11",  1'b1, 2'd0, 1'b0, 32'h11,       32'h55,       4, 32'h0,        1'b0, 2);
    chk("mem4_sb", mem[4], 32'hDEAD55EF);
    do_req("lb13",  1'b0, 2'd0, 1'b0, 32'h13,       32'h0,        3, 32'hFFFFFFDE, 1'b0, 1);
    do_req("lbu13", 1'b0, 2'd0, 1'b1, 32'h13,       32'h0,        3, 32'h000000DE, 1'b0, 1);
    do_req("lh12",  1'b0, 2'd1, 1'b0, 32'h12,       32'h0,        3, 32'hFFFFDEAD, 1'b0, 1);
    do_req("lhu10", 1'b0, 2'd1, 1'b1, 32'h10,       32'h0,        3, 32'h000055EF, 1'b0, 1);
    do_req("lb11",  1'b0, 2'd0, 1'b0, 32'h11,       32'h0,        3, 32'h00000055, 1'b0, 1);
    do_req("lw02",  1'b0, 2'd2, 1'b0, 32'h02,       32'h0,        1, 32'h0,        1'b1, 0);
    do_req("sh01",  1'b1, 2'd1, 1'b0, 32'h01,       32'h1234,     1, 32'h0,        1'b1, 0);
    do_req("sz3",   1'b0, 2'd3, 1'b0, 32'h00,       32'h0,        1, 32'h0,        1'b1, 0);
    do_req("lw1000",1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0,        1, 32'h0,        1'b1, 0);
    chk("mem4_err", mem[4], 32'hDEAD55EF);

    do_req("sw20",  1'b1, 2'd2, 1'b0, 32'h20,       32'h11223344, 2, 32'h0,        1'b0, 1);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hAA; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid:ram_en", {31'd0, bus.ram_en}, 32'd0);
    chk("rstmid:ram_we", {31'd0, bus.ram_we}, 32'd0);
    seen_en = 0;
    seen_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ram_en) seen_en++;
      if (bus.rsp_valid) seen_rsp++;
    end
    chk("rstmid:en_seen",  seen_en, 0);
    chk("rstmid:rsp_seen", seen_rsp, 0);
    rst = 1'b0;
    chk("rstmid:mem8", mem[8], 32'h11223344);
    chk("rstmid:ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstmid:cnt_store", cnt_store, 32'd0);

    do_req("lw20",  1'b0, 2'd2, 1'b0, 32'h20,       32'h0,        3, 32'h11223344, 1'b0, 1);
    do_req("sw30",  1'b1, 2'd2, 1'b0, 32'h30,       32'h01020304, 2, 32'h0,        1'b0, 1);
    do_req("sb31",  1'b1, 2'd0, 1'b0, 32'h31,       32'h000000FF, 4, 32'h0,        1'b0, 2);
    do_req("sh32",  1'b1, 2'd1, 1'b0, 32'h32,       32'h0000BEEF, 4, 32'h0,        1'b0, 2);
    chk("mem12", mem[12], 32'hBEEFFF04);
    do_req("lhu32", 1'b0, 2'd1, 1'b1, 32'h32,       32'h0,        3, 32'h0000BEEF, 1'b0, 1);
    do_req("lw06",  1'b0, 2'd2, 1'b0, 32'h06,       32'h0,        1, 32'h0,        1'b1, 0);
`ifdef RV_LSU_PERF_EN
    chk("cnt_load",  cnt_load, 32'd2);
    chk("cnt_store", cnt_store, 32'd3);
    chk("cnt_err",   cnt_err, 32'd1);
`else
    chk("cnt_load",  cnt_load, 32'd0);
    chk("cnt_store", cnt_store, 32'd0);
    chk("cnt_err",   cnt_err, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit between the core memory stage and the data-side dual-port RAM (port A).
- Accepts one memory request at a time over a valid/ready handshake and converts byte addresses to word addresses.
- Performs read-modify-write for byte and halfword stores, because the RAM has a single write enable.
- Extracts and sign- or zero-extends load data, and flags misaligned or out-of-range accesses.

Parameters:
- WIDTH, 32, data word width; only 32 is supported.
- DEPTH, 1024, RAM depth in words. AW = clog2(DEPTH) is a derived localparam used for the RAM address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as an error
- req_unsigned  in  1  zero-extend the load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data
- rsp_err  out  1  misaligned, out-of-range or illegal-size request
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM word address, equal to the latched addr[AW+1:2]
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after a read enable
- cnt_load, cnt_store, cnt_err  out  32 each  event counters (see Optional Feature)

Behaviour:
- Reset values:
  - state = IDLE
  - req_ready = 1
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0
  - ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0
  - counters = 0
- Handshake: a request is accepted on a rising edge where req_valid & req_ready. All request fields are latched at that edge. req_ready is low from the cycle after acceptance until the unit is back in IDLE.
- Error check at accept. Error if any of:
  - size = 3
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[31:AW+2] != 0
  An erroring request goes to RSP with rsp_err = 1, never drives ram_en, and returns rsp_rdata = 0.
- State machine (ram_* outputs are decoded from the registered state and the latched request):
  - IDLE -> ERR_RSP on error; -> WRITE for a word store; -> READ otherwise.
  - READ: ram_en = 1, ram_we = 0. Next: WAIT.
  - WAIT: ram_rdata is valid.
    - Load: register the extracted, extended data into rsp_rdata; next RSP.
    - Sub-word store: register the merged word (the byte/half lane selected by addr[1:0] replaced by req_wdata[7:0] or [15:0]); next WRITE.
  - WRITE: ram_en = 1, ram_we = 1, ram_wdata = the store word or the merged word. Next: RSP.
  - RSP / ERR_RSP: rsp_valid = 1 for exactly one cycle, with no backpressure. Next: IDLE.
- Latency, counted as the cycle in which rsp_valid is high after the accept edge:
  - error: 1st cycle
  - word store: 2nd cycle
  - load: 3rd cycle
  - sub-word store: 4th cycle
- Load extraction:
  - byte: lane = addr[1:0]
  - half: lane = addr[1]
  - Sign-extend from the lane MSB unless req_unsigned; word loads pass through unchanged.
- rsp_rdata: 0 for stores and errors; otherwise it holds its value until the next response.
- rsp_err is valid only while rsp_valid is high and is 0 otherwise.
- A request held on req_valid while req_ready is low is not accepted. The requester must hold it until acceptance.
- Reset mid-operation: ram_en and ram_we drop immediately (asynchronously) and no response is produced.
  - A sub-word store interrupted before WRITE leaves the RAM unchanged.

Optional Feature:
- Macro: RV_LSU_PERF_EN.
- Defined: cnt_load, cnt_store and cnt_err are 32-bit wrapping counters.
  - Each increments by 1 in the cycle rsp_valid is high, for a successful load, a successful store, or any error respectively.
  - All three clear on rst.
- Undefined: the counters are not built and the three ports are tied to 0.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF, then word load addr 0x10 -> RAM word 4 written in the WRITE cycle; load rsp_rdata = 0xDEADBEEF with rsp_valid in the 3rd cycle after accept, rsp_err = 0.
- Word 4 = 0xDEADBEEF; byte store addr 0x11, data 0x55 -> read, then write of 0xDEAD55EF; rsp_valid in the 4th cycle.
- Word 4 = 0xDEAD55EF:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x000055EF
- Error cases, each giving rsp_err = 1 in the 1st cycle with no ram_en pulse:
  - LW 0x02
  - SH 0x01
  - size 3
  - LW at 0x00001000 with DEPTH = 1024
- Assert rst during the WAIT state of SB 0x20 -> ram_en stays low, no rsp_valid; the RAM word is unchanged on a subsequent LW 0x20.
- With RV_LSU_PERF_EN: 2 loads, 3 stores, 1 error -> cnt_load = 2, cnt_store = 3, cnt_err = 1. Without the macro, all three counters read 0.
